// File: rtl/uart_tx_monitor_pkg.sv
// Shared definitions for the UART transmit-line monitor.
// Contents: receiver state encoding, frame constants and the bit-period helper.
package uart_tx_monitor_pkg;

    // 8N1 framing: one start bit, eight data bits LSB first, one stop bit.
    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_e;

    // Clock cycles per bit period; integer division, remainder dropped.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Synchronous FIFO holding received bytes until the consumer takes them.
// Ports:
//   clock, reset  posedge clock, asynchronous active-high reset
//   push_i/data_i write request and byte
//   pop_i         read request (ignored while empty)
//   data_o        head entry, forced to zero while empty
//   empty_o       no entries
//   full_o        DEPTH entries
//   accept_o      the push on this cycle is stored
// A push into a full FIFO is taken when a pop happens in the same cycle.
module uart_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             accept_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign accept_o = do_push;
    assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // When full, the write slot equals the head slot; the head has already
    // been presented on data_o this cycle, so overwriting it on a pop is safe.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_monitor.sv
// UART transmit-line monitor: deserialises an 8N1 stream, flags framing
// errors and FIFO overflow, and queues received bytes for a valid/ready
// consumer.
// Ports:
//   clock          single clock, posedge
//   reset          asynchronous, active-high
//   in_uart_tx     serial line, idle high, asynchronous to clock
//   out_data       FIFO head byte (zero while empty)
//   out_valid      FIFO non-empty
//   in_ready       consumer pops head when out_valid && in_ready
//   out_frame_err  one-cycle pulse when the stop bit is sampled low
//   out_overflow   sticky, a byte was dropped on a full FIFO; reset clears it
//   out_busy       receiver not in IDLE
//   out_count      accepted-byte counter, wraps
// Build option: define UART_MON_PRINT_EN to echo accepted bytes and report
// framing errors / first overflow on the simulator console. Port behaviour
// is identical with or without it.
//
// state     | meaning
// WAIT_IDLE | after reset or framing error, wait for the line to go high
// IDLE      | line idle, waiting for a start edge
// START     | half a bit period to the start-bit centre, re-check low
// DATA      | sample eight data bits at their centres, LSB first
// STOP      | sample the stop bit; high pushes the byte, low is an error
module uart_tx_monitor
    import uart_tx_monitor_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_uart_tx,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        in_ready,
    output logic        out_frame_err,
    output logic        out_overflow,
    output logic        out_busy,
    output logic [15:0] out_count
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0]    CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic                 overflow_q, overflow_d;
    logic [15:0]          count_q, count_d;

    logic                 stop_sample;
    logic                 fifo_push;
    logic                 fifo_accept;
    logic                 fifo_empty;
    logic                 fifo_full;

    // Preset high so reset looks like an idle line rather than a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], in_uart_tx};
        end
    end

    assign rx_s = sync_q[1];

    // The push must hit the FIFO on the same edge as the stop-bit sample so
    // the byte is visible on the following cycle; hence decoded, not registered.
    assign stop_sample = (state_q == STOP) && (cnt_q == '0);
    assign fifo_push   = stop_sample && rx_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!rx_s) begin
                        state_q <= DATA;
                        cnt_q   <= CNT_FULL;
                        idx_q   <= '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= CNT_FULL;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (rx_s) begin
                        // Leaving at mid stop bit allows back-to-back frames.
                        state_q <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_IDLE;
                    end
                end
                default: begin
                    state_q <= WAIT_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        count_d    = count_q;
        if (fifo_push && !fifo_accept) begin
            overflow_d = 1'b1;
        end
        if (fifo_accept) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    uart_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_i   (fifo_push),
        .data_i   (shift_q),
        .pop_i    (in_ready),
        .data_o   (out_data),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .accept_o (fifo_accept)
    );

    assign out_valid     = !fifo_empty;
    assign out_frame_err = frame_err_q;
    assign out_overflow  = overflow_q;
    assign out_busy      = (state_q != IDLE);
    assign out_count     = count_q;

`ifdef UART_MON_PRINT_EN
    always @(posedge clock) begin
        if (!reset) begin
            if (fifo_accept) begin
                $write("%c", shift_q);
            end
            if (stop_sample && !rx_s) begin
                $display("uart_tx_monitor: framing error at %t", $time);
            end
            if (fifo_push && !fifo_accept && !overflow_q) begin
                $display("uart_tx_monitor: warning, FIFO full, byte 0x%02h dropped at %t (full=%0b)",
                         shift_q, $time, fifo_full);
            end
        end
    end
`else
    // Full flag only matters to the console reporting above.
    logic unused_full;
    assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_uart_tx_monitor.sv
module tb_uart_tx_monitor;

    localparam int CPB   = 10;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_uart_tx = 1'b1;
    logic        in_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_frame_err;
    logic        out_overflow;
    logic        out_busy;
    logic [15:0] out_count;

    uart_tx_monitor #(
        .CLK_HZ     (100000000),
        .BAUD       (10000000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_uart_tx    (in_uart_tx),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_frame_err (out_frame_err),
        .out_overflow  (out_overflow),
        .out_busy      (out_busy),
        .out_count     (out_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Model: bytes the line protocol says must come out, in order.
    byte unsigned exp_q[$];
    int  model_count  = 0;
    bit  model_ovf    = 1'b0;
    int  ferr_cnt     = 0;
    int  valid_cycles = 0;
    logic prev_ferr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one frame; each bit lasts CPB clocks. With ready_at_stop, in_ready
    // rises so that it is high on the edge that samples the stop-bit centre.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ready_at_stop);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            in_uart_tx = bits[i];
            if (i == 9 && ready_at_stop) begin
                repeat (7) tick();
                in_ready = 1'b1;
                repeat (3) tick();
            end else begin
                repeat (CPB) tick();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ready_at_stop);
        if (!stop_ok) begin
            // discarded, no push
        end else if (in_ready || ready_at_stop || exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
            model_count++;
        end else begin
            model_ovf = 1'b1;
        end
        send_frame(b, stop_ok, ready_at_stop);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) valid_cycles++;
            if (out_frame_err) begin
                ferr_cnt++;
                if (prev_ferr) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ferr_width: frame error high 2 cycles, expected 1");
                end
            end
            prev_ferr = out_frame_err;
            if (out_valid && in_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pop_unexpected: got byte 0x%0h, expected none", out_data);
                end else begin
                    check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end else if (exp_q.size() == 0) begin
                check("valid_when_empty", 32'(out_valid), 32'd0);
            end
        end else begin
            prev_ferr = 1'b0;
        end
    end

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ferr", 32'(out_frame_err), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd1);
        check("rst_count", 32'(out_count), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_busy", 32'(out_busy), 32'd0);

        // 1: back-to-back frames
        valid_cycles = 0;
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b0);
        repeat (5) tick();
        check("t1_valid_cycles", 32'(valid_cycles), 32'd2);
        check("t1_count", 32'(out_count), 32'd2);
        check("t1_count_model", 32'(out_count), 32'(model_count));
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: overflow with consumer stalled
        in_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 1'b0);
        repeat (5) tick();
        check("t2_ovf", 32'(out_overflow), 32'd1);
        check("t2_ovf_model", 32'(out_overflow), 32'(model_ovf));
        check("t2_count", 32'(out_count), 32'd18);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_head", 32'(out_data), 32'h00);
        check("t2_queued", 32'(exp_q.size()), 32'd16);
        in_ready = 1'b1;
        repeat (25) tick();
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_valid_after", 32'(out_valid), 32'd0);

        // 3: stop bit low, line then held low
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (30) tick();
        check("t3_ferr_pulses", 32'(ferr_cnt), 32'd1);
        check("t3_busy_low_line", 32'(out_busy), 32'd1);
        check("t3_count", 32'(out_count), 32'd18);
        in_uart_tx = 1'b1;
        repeat (5) tick();
        check("t3_busy_line_high", 32'(out_busy), 32'd0);
        send_byte(8'h5A, 1'b1, 1'b0);
        repeat (5) tick();
        check("t3_count_after", 32'(out_count), 32'd19);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: short glitch on idle line
        in_uart_tx = 1'b0;
        repeat (3) tick();
        check("t4_busy_glitch", 32'(out_busy), 32'd1);
        in_uart_tx = 1'b1;
        repeat (12) tick();
        check("t4_busy_after", 32'(out_busy), 32'd0);
        check("t4_ferr", 32'(ferr_cnt), 32'd1);
        check("t4_count", 32'(out_count), 32'd19);
        check("t4_ovf_sticky", 32'(out_overflow), 32'd1);

        // 5: reset in the middle of 0x81 with the line low
        in_ready = 1'b0;
        send_byte(8'h99, 1'b1, 1'b0);
        repeat (3) tick();
        check("t5_queued", 32'(out_valid), 32'd1);
        in_uart_tx = 1'b0;
        repeat (CPB) tick();
        in_uart_tx = 1'b1;
        repeat (CPB) tick();
        in_uart_tx = 1'b0;
        repeat (5) tick();
        check("t5_busy_mid", 32'(out_busy), 32'd1);
        reset = 1'b1;
        in_ready = 1'b1;
        exp_q.delete();
        model_count = 0;
        model_ovf = 1'b0;
        repeat (2) tick();
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_count", 32'(out_count), 32'd0);
        check("t5_rst_ovf", 32'(out_overflow), 32'd0);
        check("t5_rst_busy", 32'(out_busy), 32'd1);
        reset = 1'b0;
        repeat (130) tick();
        check("t5_busy_low", 32'(out_busy), 32'd1);
        check("t5_count_low", 32'(out_count), 32'd0);
        in_uart_tx = 1'b1;
        repeat (10) tick();
        check("t5_busy_idle", 32'(out_busy), 32'd0);
        send_byte(8'h7E, 1'b1, 1'b0);
        repeat (5) tick();
        check("t5_count", 32'(out_count), 32'd1);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6: full FIFO, pop arrives on the stop-bit sample cycle
        in_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1);
        repeat (25) tick();
        check("t6_ovf", 32'(out_overflow), 32'd0);
        check("t6_count", 32'(out_count), 32'd18);
        check("t6_count_model", 32'(out_count), 32'(model_count));
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
